// File: rtl/eqchk_pkg.sv
// Shared types and constants for the dual-instance equivalence-check sequencer.
// Stimulus struct packs wire0..3 with wire0 in the LSBs, matching LFSR state bits [61:0].
package eqchk_pkg;

  localparam int EQCHK_Y_W    = 91;
  localparam int EQCHK_LFSR_W = 64;
  localparam int EQCHK_IDX_W  = 16;
  localparam int EQCHK_CNT_W  = 32;

  localparam int EQCHK_W0_W = 19;
  localparam int EQCHK_W1_W = 18;
  localparam int EQCHK_W2_W = 11;
  localparam int EQCHK_W3_W = 14;
  localparam int EQCHK_STIM_W = EQCHK_W0_W + EQCHK_W1_W + EQCHK_W2_W + EQCHK_W3_W;

  // Right-shifting Galois form of taps 64,63,61,60.
  localparam logic [EQCHK_LFSR_W-1:0] EQCHK_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } eqchk_state_e;

  typedef struct packed {
    logic signed [EQCHK_W3_W-1:0] w3;
    logic signed [EQCHK_W2_W-1:0] w2;
    logic signed [EQCHK_W1_W-1:0] w1;
    logic signed [EQCHK_W0_W-1:0] w0;
  } eqchk_stim_t;

  function automatic logic [EQCHK_LFSR_W-1:0] eqchk_lfsr_next(input logic [EQCHK_LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? EQCHK_TAPS : '0);
  endfunction

endpackage

// File: rtl/eqchk_if.sv
// Stimulus / result bundle between the sequencer (master) and the harness holding the DUT pair (slave).
interface eqchk_if;
  import eqchk_pkg::*;

  logic                          start;
  logic signed [EQCHK_W0_W-1:0]  wire0;
  logic signed [EQCHK_W1_W-1:0]  wire1;
  logic signed [EQCHK_W2_W-1:0]  wire2;
  logic signed [EQCHK_W3_W-1:0]  wire3;
  logic [EQCHK_Y_W-1:0]          y_1;
  logic [EQCHK_Y_W-1:0]          y_2;
  logic                          busy;
  logic                          done;
  logic                          pass;
  logic [EQCHK_IDX_W-1:0]        fail_idx;
  logic [EQCHK_Y_W-1:0]          fail_xor;

  modport master (
    input  start, y_1, y_2,
    output wire0, wire1, wire2, wire3, busy, done, pass, fail_idx, fail_xor
  );

  modport slave (
    output start, y_1, y_2,
    input  wire0, wire1, wire2, wire3, busy, done, pass, fail_idx, fail_xor
  );

endinterface

// File: rtl/eqchk_lfsr.sv
// 64-bit Galois LFSR: seed load has priority over step; state resets to SEED.
module eqchk_lfsr
  import eqchk_pkg::*;
#(
  parameter logic [EQCHK_LFSR_W-1:0] SEED = 64'h1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_step,
  output logic [EQCHK_LFSR_W-1:0] o_state
);

  logic [EQCHK_LFSR_W-1:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= SEED;
    end else if (i_step) begin
      r_state <= eqchk_lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/equiv_check_sequencer.sv
// Bounded equivalence run: drives LFSR stimulus to a DUT pair, compares y_1/y_2 LAT cycles later.
// Optional EQCHK_STOP_ON_FAIL_EN: first mismatch ends the run early (DONE next cycle).
module equiv_check_sequencer
  import eqchk_pkg::*;
#(
  parameter int                      NUM_VECTORS = 256,
  parameter int                      WARMUP      = 4,
  parameter int                      LAT         = 1,
  parameter logic [EQCHK_LFSR_W-1:0] SEED        = 64'h1
) (
  input  logic     clk,
  input  logic     rst,
  eqchk_if.master  bus
);

  if (NUM_VECTORS < 1 || NUM_VECTORS > 65536) begin : g_bad_num_vectors
    $error("NUM_VECTORS must be in 1..65536");
  end
  if (WARMUP < 0 || LAT < 0) begin : g_bad_timing
    $error("WARMUP and LAT must be non-negative");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("SEED must be nonzero");
  end

  eqchk_state_e             r_state;
  eqchk_state_e             w_state_nxt;
  logic [EQCHK_CNT_W-1:0]   r_cnt;
  eqchk_stim_t              r_stim;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_pass;
  logic                     r_fail_seen;
  logic [EQCHK_IDX_W-1:0]   r_fail_idx;
  logic [EQCHK_Y_W-1:0]     r_fail_xor;

  logic [EQCHK_LFSR_W-1:0]  w_lfsr_q;
  logic [EQCHK_STIM_W-1:0]  w_lfsr_nxt;
  logic                     w_start_acc;
  logic                     w_step;
  logic                     w_cmp_vld;
  logic [EQCHK_IDX_W-1:0]   w_cmp_tag;
  logic                     w_mis;
  logic                     w_stop;
  logic                     w_nxt_active;

  assign w_start_acc  = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_step       = (r_state == ST_WARMUP) || (r_state == ST_RUN);
  assign w_nxt_active = (w_state_nxt == ST_WARMUP) || (w_state_nxt == ST_RUN);
  assign w_mis        = w_cmp_vld && (r_state == ST_RUN || r_state == ST_DRAIN) &&
                        (bus.y_1 != bus.y_2);
  assign w_lfsr_nxt   = EQCHK_STIM_W'(eqchk_lfsr_next(w_lfsr_q));

`ifdef EQCHK_STOP_ON_FAIL_EN
  assign w_stop = w_mis;
`else
  assign w_stop = 1'b0;
`endif

  eqchk_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_start_acc),
    .i_step  (w_step),
    .o_state (w_lfsr_q)
  );

  // The tag of a RUN vector emerges exactly when the pair's response to it is on y_1/y_2.
  if (LAT == 0) begin : g_lat0
    assign w_cmp_vld = (r_state == ST_RUN);
    assign w_cmp_tag = r_cnt[EQCHK_IDX_W-1:0];
  end else begin : g_pipe
    logic [LAT-1:0]         r_pv;
    logic [EQCHK_IDX_W-1:0] r_pt [LAT];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pv <= '0;
        for (int i = 0; i < LAT; i++) r_pt[i] <= '0;
      end else if (w_start_acc) begin
        r_pv <= '0;
      end else begin
        r_pv[0] <= (r_state == ST_RUN);
        r_pt[0] <= r_cnt[EQCHK_IDX_W-1:0];
        for (int i = 1; i < LAT; i++) begin
          r_pv[i] <= r_pv[i-1];
          r_pt[i] <= r_pt[i-1];
        end
      end
    end

    assign w_cmp_vld = r_pv[LAT-1];
    assign w_cmp_tag = r_pt[LAT-1];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) w_state_nxt = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
      end
      ST_WARMUP: begin
        if (r_cnt == EQCHK_CNT_W'(WARMUP - 1)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_stop)                                       w_state_nxt = ST_DONE;
        else if (r_cnt == EQCHK_CNT_W'(NUM_VECTORS - 1))  w_state_nxt = (LAT > 0) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: begin
        if (w_stop || r_cnt == EQCHK_CNT_W'(LAT - 1))     w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_stim      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_seen <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_xor  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_WARMUP) || (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      r_done  <= (w_state_nxt == ST_DONE);
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;

      // Stimulus register always shows the vector of the current WARMUP/RUN cycle.
      if (w_start_acc)                 r_stim <= eqchk_stim_t'(SEED[EQCHK_STIM_W-1:0]);
      else if (w_step && w_nxt_active) r_stim <= eqchk_stim_t'(w_lfsr_nxt);

      if (w_start_acc) begin
        r_pass      <= 1'b0;
        r_fail_seen <= 1'b0;
        r_fail_idx  <= '0;
        r_fail_xor  <= '0;
      end else begin
        if (w_mis && !r_fail_seen) begin
          r_fail_seen <= 1'b1;
          r_fail_idx  <= w_cmp_tag;
          r_fail_xor  <= bus.y_1 ^ bus.y_2;
        end
        if (w_state_nxt == ST_DONE && r_state != ST_DONE) r_pass <= !(r_fail_seen || w_mis);
      end
    end
  end

  assign bus.wire0    = r_stim.w0;
  assign bus.wire1    = r_stim.w1;
  assign bus.wire2    = r_stim.w2;
  assign bus.wire3    = r_stim.w3;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass     = r_pass;
  assign bus.fail_idx = r_fail_idx;
  assign bus.fail_xor = r_fail_xor;

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// Directed bench: a registered (LAT=1) DUT-pair model with a per-cycle corruption mask on y_2.
module tb_equiv_check_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eqchk_if u_if ();

  equiv_check_sequencer #(
    .NUM_VECTORS (256),
    .WARMUP      (4),
    .LAT         (1),
    .SEED        (64'h1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  logic [90:0] r_y1;
  logic [90:0] inj;
  logic [61:0] cur;

  always @(posedge clk)
    r_y1 <= {u_if.wire0[10:0], u_if.wire3, u_if.wire1[3:0],
             u_if.wire3, u_if.wire2, u_if.wire1, u_if.wire0};

  assign u_if.y_1 = r_y1;
  assign u_if.y_2 = r_y1 ^ inj;
  assign cur = {u_if.wire3, u_if.wire2, u_if.wire1, u_if.wire0};

  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] mnext(input logic [63:0] s);
    logic [63:0] taps;
    taps = 64'hD800_0000_0000_0000;
    return (s >> 1) ^ (s[0] ? taps : 64'h0);
  endfunction

  // Stimulus word expected during overall vector k of a run (warmup vectors included).
  function automatic logic [61:0] vec(input int k);
    logic [63:0] s;
    s = 64'h1;
    for (int i = 0; i < k; i++) s = mnext(s);
    return s[61:0];
  endfunction

  task automatic wait_e(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge that samples start (call it E0).
  task automatic start_pulse();
    @(negedge clk);
    u_if.start = 1'b1;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (u_if.busy !== 1'b0 || u_if.done !== 1'b0 || u_if.pass !== 1'b0) begin
      bad++; $display("FAIL reset_flags got busy=%b done=%b pass=%b want 0", u_if.busy, u_if.done, u_if.pass); end
    total++; if (cur !== 62'h0 || u_if.fail_idx !== 16'h0 || u_if.fail_xor !== 91'h0) begin
      bad++; $display("FAIL reset_data got wires=%h idx=%h xor=%h want 0", cur, u_if.fail_idx, u_if.fail_xor); end
    @(negedge clk); rst = 1'b0;
    wait_e(3);
    total++; if (u_if.busy !== 1'b0 || u_if.done !== 1'b0) begin
      bad++; $display("FAIL idle_hold got busy=%b done=%b want 0", u_if.busy, u_if.done); end
    start_pulse();
    wait_e(100);
    total++; if (u_if.busy !== 1'b1) begin
      bad++; $display("FAIL midrun_busy got %b want 1", u_if.busy); end
    @(negedge clk); rst = 1'b1;
    #1;
    total++; if (u_if.busy !== 1'b0 || u_if.done !== 1'b0 || cur !== 62'h0) begin
      bad++; $display("FAIL abort got busy=%b done=%b wires=%h want 0/0/0", u_if.busy, u_if.done, cur); end
    @(negedge clk); rst = 1'b0;
    wait_e(4);
    total++; if (u_if.busy !== 1'b0 || u_if.done !== 1'b0 || u_if.pass !== 1'b0) begin
      bad++; $display("FAIL after_abort got busy=%b done=%b pass=%b want 0", u_if.busy, u_if.done, u_if.pass); end
  endtask

  task automatic test_back_to_back();
    start_pulse();
    total++; if (cur !== vec(0) || u_if.busy !== 1'b1 || u_if.done !== 1'b0) begin
      bad++; $display("FAIL first_vec got wires=%h busy=%b want %h busy=1", cur, u_if.busy, vec(0)); end
    wait_e(1);
    total++; if (cur !== vec(1)) begin
      bad++; $display("FAIL second_vec got %h want %h", cur, vec(1)); end
    wait_e(49);
    start_pulse();
    wait_e(209);
    total++; if (u_if.done !== 1'b0 || u_if.busy !== 1'b1) begin
      bad++; $display("FAIL drain_cycle got done=%b busy=%b want 0/1", u_if.done, u_if.busy); end
    u_if.start = 1'b1;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    total++; if (u_if.done !== 1'b1 || u_if.busy !== 1'b0 || u_if.pass !== 1'b1) begin
      bad++; $display("FAIL done_at_261 got done=%b busy=%b pass=%b want 1/0/1", u_if.done, u_if.busy, u_if.pass); end
    wait_e(1);
    total++; if (u_if.done !== 1'b1 || cur !== vec(259)) begin
      bad++; $display("FAIL done_hold got done=%b wires=%h want 1 %h", u_if.done, cur, vec(259)); end
  endtask

  task automatic test_mismatch17();
    logic [90:0] m1;
    logic [90:0] m2;
    m1 = '0; m1[90] = 1'b1;
    m2 = '0; m2[5]  = 1'b1;
    start_pulse();
    total++; if (u_if.done !== 1'b0 || u_if.pass !== 1'b0 || u_if.fail_xor !== 91'h0) begin
      bad++; $display("FAIL start_clear got done=%b pass=%b xor=%h want 0", u_if.done, u_if.pass, u_if.fail_xor); end
    wait_e(22); inj = m1;
    wait_e(1);  inj = '0;
    wait_e(22); inj = m2;
    wait_e(1);  inj = '0;
    wait_e(215);
    total++; if (u_if.done !== 1'b1 || u_if.pass !== 1'b0 || u_if.fail_idx !== 16'd17) begin
      bad++; $display("FAIL mis17 got done=%b pass=%b idx=%0d want 1/0/17", u_if.done, u_if.pass, u_if.fail_idx); end
    total++; if (u_if.fail_xor !== m1) begin
      bad++; $display("FAIL mis17_xor got %h want %h", u_if.fail_xor, m1); end
  endtask

  task automatic test_warmup_only();
    logic [90:0] m;
    m = 91'h7_0000_1234;
    start_pulse();
    wait_e(1);   inj = m;
    wait_e(4);   inj = '0;
    wait_e(256);
    total++; if (u_if.done !== 1'b1 || u_if.pass !== 1'b1 || u_if.fail_xor !== 91'h0) begin
      bad++; $display("FAIL warmup_mis got done=%b pass=%b xor=%h want 1/1/0", u_if.done, u_if.pass, u_if.fail_xor); end
  endtask

  task automatic test_edges();
    logic [90:0] m;
    m = 91'h1;
    start_pulse();
    wait_e(5); inj = m;
    wait_e(1); inj = '0;
    wait_e(255);
    total++; if (u_if.done !== 1'b1 || u_if.pass !== 1'b0 || u_if.fail_idx !== 16'd0 || u_if.fail_xor !== m) begin
      bad++; $display("FAIL first_cmp got done=%b pass=%b idx=%0d xor=%h want 1/0/0/%h", u_if.done, u_if.pass, u_if.fail_idx, u_if.fail_xor, m); end
    m = 91'h3 << 40;
    start_pulse();
    wait_e(260); inj = m;
    wait_e(1);   inj = '0;
    total++; if (u_if.done !== 1'b1 || u_if.pass !== 1'b0 || u_if.fail_idx !== 16'd255 || u_if.fail_xor !== m) begin
      bad++; $display("FAIL last_cmp got done=%b pass=%b idx=%0d xor=%h want 1/0/255/%h", u_if.done, u_if.pass, u_if.fail_idx, u_if.fail_xor, m); end
  endtask

  task automatic test_stop_on_fail();
    logic [90:0] m;
    m = 91'h10;
    start_pulse();
    wait_e(8); inj = m;
`ifdef EQCHK_STOP_ON_FAIL_EN
    total++; if (u_if.done !== 1'b0 || u_if.busy !== 1'b1) begin
      bad++; $display("FAIL stop_pre got done=%b busy=%b want 0/1", u_if.done, u_if.busy); end
    wait_e(1); inj = '0;
    total++; if (u_if.done !== 1'b1 || u_if.pass !== 1'b0 || u_if.fail_idx !== 16'd3) begin
      bad++; $display("FAIL stop_done got done=%b pass=%b idx=%0d want 1/0/3", u_if.done, u_if.pass, u_if.fail_idx); end
    wait_e(3);
    total++; if (cur !== vec(8)) begin
      bad++; $display("FAIL stop_freeze got %h want %h", cur, vec(8)); end
`else
    wait_e(1); inj = '0;
    total++; if (u_if.done !== 1'b0 || u_if.busy !== 1'b1) begin
      bad++; $display("FAIL full_window got done=%b busy=%b want 0/1", u_if.done, u_if.busy); end
    wait_e(252);
    total++; if (u_if.done !== 1'b1 || u_if.pass !== 1'b0 || u_if.fail_idx !== 16'd3) begin
      bad++; $display("FAIL idx3 got done=%b pass=%b idx=%0d want 1/0/3", u_if.done, u_if.pass, u_if.fail_idx); end
`endif
  endtask

  task automatic test_rerun();
    logic [61:0] run_a [8];
    int          diffs;
    diffs = 0;
    start_pulse();
    for (int k = 0; k < 8; k++) begin
      run_a[k] = cur;
      if (k < 7) wait_e(1);
    end
    wait_e(254);
    total++; if (u_if.done !== 1'b1) begin
      bad++; $display("FAIL rerun_done got %b want 1", u_if.done); end
    start_pulse();
    for (int k = 0; k < 8; k++) begin
      if (cur !== run_a[k] || cur !== vec(k)) diffs++;
      if (k < 7) wait_e(1);
    end
    total++; if (diffs != 0) begin
      bad++; $display("FAIL rerun_seq got %0d differing vectors want 0", diffs); end
  endtask

  initial begin
    rst        = 1'b1;
    u_if.start = 1'b0;
    inj        = '0;
    test_reset();
    test_back_to_back();
    test_mismatch17();
    test_warmup_only();
    test_edges();
    test_stop_on_fail();
    test_rerun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
